// File: rtl/fir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_input_ctrl
// Purpose  : Front-end of the FIR top level. Decodes the slow pin-driven
//            command strobe into (a) a sample stream behind a 2-entry FIFO
//            with a valid/ready handshake and (b) a coefficient bank that is
//            loaded into a shadow copy and committed atomically, so the
//            filter never sees a half-loaded tap set.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            ena               - enable; gates command detection
//            cmd_strobe        - asynchronous strobe, one command per rise
//            cmd_op[1:0]       - 00 SAMPLE, 01 LOAD_START, 10 COEF_WRITE,
//                                11 ABORT/CLEAR
//            data_in           - command payload
//            sample_out/valid  - FIFO head and its valid flag
//            sample_ready      - downstream accepts the head sample
//            coef_flat         - active bank, tap i at [i*COEF_W +: COEF_W]
//            coef_update       - one-cycle pulse on bank commit
//            loading           - high while a bank load is in progress
//            err[1:0]          - sticky: bit0 overflow, bit1 protocol error
// Revision : 1.0 - initial release
// ============================================================================
module fir_input_ctrl #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int NUM_TAPS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       cmd_strobe,
  input  logic [1:0]                 cmd_op,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [NUM_TAPS*COEF_W-1:0] coef_flat,
  output logic                       coef_update,
  output logic                       loading,
  output logic [1:0]                 err
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [1:0]       c_op_sample     = 2'b00;
  localparam logic [1:0]       c_op_load_start = 2'b01;
  localparam logic [1:0]       c_op_coef_write = 2'b10;
  localparam logic [1:0]       c_op_abort      = 2'b11;
  localparam logic [IDX_W-1:0] c_last_idx      = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detect
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic w_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= cmd_strobe;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // The synchroniser keeps running while ena is low, so a strobe that rose
  // during ena=0 has already been consumed by r_dly and is lost for good.
  assign w_cmd = r_sync2 & ~r_dly & ena;

  // --------------------------------------------------------------------------
  // Sample FIFO (2 entries, r_buf0 is always the head)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_sample_cmd;
  logic              w_push;
  logic              w_overflow;

  assign sample_valid = (r_count != 2'd0);
  assign sample_out   = r_buf0;
  assign w_pop        = sample_valid & sample_ready;
  assign w_sample_cmd = w_cmd & (cmd_op == c_op_sample);
  // A full FIFO still accepts a sample if the head leaves in the same cycle.
  assign w_push       = w_sample_cmd & ((r_count != 2'd2) | w_pop);
  assign w_overflow   = w_sample_cmd & ~w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_buf0 <= data_in;
          else                 r_buf1 <= data_in;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; only the contents shift.
          if (r_count == 2'd1) begin
            r_buf0 <= data_in;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient load FSM
  // --------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [1:0]              r_err;
  logic [1:0]              w_err_nxt;
  logic                    w_shadow_we;
  logic                    w_commit;
  logic [COEF_W-1:0]       w_coef_data;
  logic [COEF_W-1:0]       r_shadow [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0] w_bank;
  logic [NUM_TAPS*COEF_W-1:0] r_coef;
  logic                    r_update;

  assign w_coef_data = data_in[COEF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shadow_we = 1'b0;
    w_commit    = 1'b0;
    w_err_nxt   = r_err | {1'b0, w_overflow};
    if (w_cmd) begin
      case (r_state)
        ST_IDLE: begin
          case (cmd_op)
            c_op_load_start: begin
              w_state_nxt = ST_LOAD;
              w_idx_nxt   = '0;
            end
            c_op_coef_write: w_err_nxt[1] = 1'b1;
            // Only one command per edge, so no overflow can be lost here.
            c_op_abort:      w_err_nxt    = 2'b00;
            default: ;
          endcase
        end
        ST_LOAD: begin
          case (cmd_op)
            c_op_load_start: begin
              w_err_nxt[1] = 1'b1;
              w_idx_nxt    = '0;
            end
            c_op_coef_write: begin
              w_shadow_we = 1'b1;
              if (r_idx == c_last_idx) begin
                w_commit    = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
              end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
              end
            end
            c_op_abort: begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // The final tap is written in the commit cycle itself, so the committed
  // bank takes it straight from the payload rather than from the shadow.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_bank
    if (gi == NUM_TAPS - 1) begin : g_last
      assign w_bank[gi*COEF_W +: COEF_W] = w_coef_data;
    end else begin : g_shadow
      assign w_bank[gi*COEF_W +: COEF_W] = r_shadow[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_err    <= 2'b00;
      r_coef   <= '0;
      r_update <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
      r_update <= w_commit;
      if (w_shadow_we) begin
        r_shadow[r_idx] <= w_coef_data;
      end
      if (w_commit) begin
        r_coef <= w_bank;
      end
    end
  end

  assign coef_flat   = r_coef;
  assign coef_update = r_update;
  assign loading     = (r_state == ST_LOAD);
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_input_ctrl
// Purpose  : Self-checking bench for fir_input_ctrl. A queue/array model of
//            the command protocol is compared with the DUT every cycle, and
//            directed sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_input_ctrl;

  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int NUM_TAPS = 4;
  localparam int HIST     = 8192;

  localparam logic [1:0] OP_S = 2'b00;
  localparam logic [1:0] OP_L = 2'b01;
  localparam logic [1:0] OP_W = 2'b10;
  localparam logic [1:0] OP_A = 2'b11;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       ena = 1'b1;
  logic                       cmd_strobe = 1'b0;
  logic [1:0]                 cmd_op = 2'b00;
  logic [DATA_W-1:0]          data_in = '0;
  logic [DATA_W-1:0]          sample_out;
  logic                       sample_valid;
  logic                       sample_ready = 1'b0;
  logic [NUM_TAPS*COEF_W-1:0] coef_flat;
  logic                       coef_update;
  logic                       loading;
  logic [1:0]                 err;

  fir_input_ctrl #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_strobe(cmd_strobe),
    .cmd_op(cmd_op), .data_in(data_in), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .coef_flat(coef_flat), .coef_update(coef_update), .loading(loading),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_seen = 0;
  int last_t0 = 0;
  bit rand_ready = 1'b0;
  bit vhist [HIST];
  logic [7:0] ohist [HIST];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int       at;
    bit [1:0] op;
    bit [7:0] d;
  } cmd_t;

  cmd_t      pend [$];
  bit [7:0]  q [$];
  bit [7:0]  m_sh [NUM_TAPS];
  bit [31:0] m_coef;
  int        m_idx;
  bit        m_load;
  bit [1:0]  m_err;
  bit        m_upd;

  task automatic model_reset();
    q.delete();
    pend.delete();
    foreach (m_sh[i]) m_sh[i] = 8'h00;
    m_coef = 32'h0; m_idx = 0; m_load = 1'b0; m_err = 2'b00; m_upd = 1'b0;
  endtask

  task automatic model_apply(input cmd_t c, input bit full);
    case (c.op)
      OP_S: if (full) m_err[0] = 1'b1; else q.push_back(c.d);
      OP_L: begin
        if (m_load) m_err[1] = 1'b1;
        m_load = 1'b1;
        m_idx  = 0;
      end
      OP_W: begin
        if (!m_load) begin
          m_err[1] = 1'b1;
        end else begin
          m_sh[m_idx] = c.d;
          m_idx++;
          if (m_idx == NUM_TAPS) begin
            for (int i = 0; i < NUM_TAPS; i++) m_coef[i*8 +: 8] = m_sh[i];
            m_upd  = 1'b1;
            m_idx  = 0;
            m_load = 1'b0;
          end
        end
      end
      default: begin
        if (m_load) begin
          m_load = 1'b0;
          m_idx  = 0;
        end else begin
          m_err = 2'b00;
        end
      end
    endcase
  endtask

  // Model step on every rising edge, then compare just after it.
  initial begin
    bit   pop;
    bit   full;
    cmd_t c;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
      end else begin
        m_upd = 1'b0;
        pop   = (q.size() > 0) && sample_ready;
        full  = (q.size() == 2) && !pop;
        if (pop) void'(q.pop_front());
        if (pend.size() > 0 && pend[0].at == cyc) begin
          c = pend.pop_front();
          if (ena) model_apply(c, full);
        end
      end
      #1;
      if (cyc < HIST) begin
        vhist[cyc] = sample_valid;
        ohist[cyc] = sample_out;
      end
      if (coef_update === 1'b1) upd_seen++;
      chk("sample_valid", {31'b0, sample_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) chk("sample_out", {24'b0, sample_out}, {24'b0, q[0]});
      chk("coef_flat", coef_flat, m_coef);
      chk("coef_update", {31'b0, coef_update}, {31'b0, m_upd});
      chk("loading", {31'b0, loading}, {31'b0, m_load});
      chk("err", {30'b0, err}, {30'b0, m_err});
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
    end
  end

  // One command: strobe high 2 cycles, payload held 6 cycles from the rise.
  // The first edge to sample the strobe is cyc+1; the command lands 2 later.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit en);
    @(negedge clk);
    ena        = en;
    cmd_op     = op;
    data_in    = d;
    cmd_strobe = 1'b1;
    last_t0    = cyc;
    pend.push_back('{cyc + 3, op, d});
    repeat (2) @(negedge clk);
    cmd_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t0;
    int u0;
    bit [1:0] op;
    int r;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, sample_valid}, 32'd0);
    chk("rst_coef", coef_flat, 32'h0);
    chk("rst_err", {30'b0, err}, 32'd0);
    chk("rst_loading", {31'b0, loading}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of a single sample with ready held high.
    sample_ready = 1'b1;
    send(OP_S, 8'h5A, 1'b1);
    t0 = last_t0;
    chk("lat_k+1_valid", {31'b0, vhist[t0+2]}, 32'd0);
    chk("lat_k+2_valid", {31'b0, vhist[t0+3]}, 32'd1);
    chk("lat_k+2_data", {24'b0, ohist[t0+3]}, 32'h5A);
    chk("lat_k+3_valid", {31'b0, vhist[t0+4]}, 32'd0);

    // Overflow with ready low, then drain.
    sample_ready = 1'b0;
    send(OP_S, 8'h11, 1'b1);
    send(OP_S, 8'h22, 1'b1);
    send(OP_S, 8'h33, 1'b1);
    chk("ovf_err", {30'b0, err}, 32'd1);
    chk("ovf_head", {24'b0, sample_out}, 32'h11);
    sample_ready = 1'b1;
    @(negedge clk);
    chk("drain_second", {24'b0, sample_out}, 32'h22);
    chk("drain_second_valid", {31'b0, sample_valid}, 32'd1);
    @(negedge clk);
    chk("drain_empty", {31'b0, sample_valid}, 32'd0);
    send(OP_A, 8'h00, 1'b1);
    chk("abort_clears_err", {30'b0, err}, 32'd0);

    // Full bank load.
    u0 = upd_seen;
    send(OP_L, 8'h00, 1'b1);
    chk("load_loading", {31'b0, loading}, 32'd1);
    send(OP_W, 8'h01, 1'b1);
    send(OP_W, 8'h02, 1'b1);
    send(OP_W, 8'h03, 1'b1);
    chk("load_not_committed", coef_flat, 32'h0);
    send(OP_W, 8'h04, 1'b1);
    chk("bank_commit", coef_flat, 32'h04030201);
    chk("bank_loading_low", {31'b0, loading}, 32'd0);
    chk("bank_one_update", upd_seen - u0, 32'd1);

    // Aborted load keeps the old bank.
    u0 = upd_seen;
    send(OP_L, 8'h00, 1'b1);
    send(OP_W, 8'hAA, 1'b1);
    send(OP_W, 8'hBB, 1'b1);
    send(OP_A, 8'h00, 1'b1);
    chk("abort_bank_kept", coef_flat, 32'h04030201);
    chk("abort_no_update", upd_seen - u0, 32'd0);
    chk("abort_loading", {31'b0, loading}, 32'd0);
    chk("abort_err_kept", {30'b0, err}, 32'd0);

    // Protocol error, then samples interleaved with a load.
    send(OP_W, 8'h99, 1'b1);
    chk("idle_write_err", {30'b0, err}, 32'd2);
    rand_ready = 1'b1;
    send(OP_L, 8'h00, 1'b1);
    send(OP_S, 8'h61, 1'b1);
    send(OP_W, 8'h10, 1'b1);
    send(OP_S, 8'h62, 1'b1);
    send(OP_W, 8'h20, 1'b1);
    send(OP_W, 8'h30, 1'b1);
    send(OP_S, 8'h63, 1'b1);
    send(OP_W, 8'h40, 1'b1);
    chk("interleave_bank", coef_flat, 32'h40302010);

    // Reset in the middle of a load.
    rand_ready   = 1'b0;
    sample_ready = 1'b1;
    send(OP_L, 8'h00, 1'b1);
    send(OP_W, 8'h55, 1'b1);
    send(OP_W, 8'h66, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midload_rst_coef", coef_flat, 32'h0);
    chk("midload_rst_loading", {31'b0, loading}, 32'd0);
    chk("midload_rst_err", {30'b0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Strobes while disabled are lost; FSM holds.
    send(OP_S, 8'h77, 1'b0);
    chk("ena_low_no_sample", {31'b0, sample_valid}, 32'd0);
    send(OP_L, 8'h00, 1'b1);
    send(OP_A, 8'h00, 1'b0);
    chk("ena_low_fsm_hold", {31'b0, loading}, 32'd1);
    send(OP_A, 8'h00, 1'b1);
    chk("ena_high_abort", {31'b0, loading}, 32'd0);

    // Randomized command stream.
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = OP_S;
      else if (r < 45) op = OP_L;
      else if (r < 90) op = OP_W;
      else             op = OP_A;
      send(op, 8'($urandom), $urandom_range(0, 9) != 0);
    end
    rand_ready   = 1'b0;
    sample_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_input_ctrl.md
Name: fir_input_ctrl

Overview:
Upstream front-end of the FIR filter top level. It decodes a slow, pin-driven command strobe protocol into two outputs: a sample stream with a valid/ready handshake, and an atomically committed coefficient bank. It sits between the chip pins (ui_in/uio_in) and the FIR datapath. The filter never sees a half-loaded tap set.

Parameters:
DATA_W, 8, sample width and pin data-bus width
COEF_W, 8, coefficient width (must be ≤ DATA_W; the low COEF_W bits of data_in are used)
NUM_TAPS, 4, number of coefficients, range 2..16

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, strobes are ignored and state is held
cmd_strobe  input  1  asynchronous command strobe from pin; its rising edge issues one command
cmd_op  input  2  opcode: 00 SAMPLE, 01 LOAD_START, 10 COEF_WRITE, 11 ABORT/CLEAR
data_in  input  DATA_W  command payload
sample_out  output  DATA_W  head of the sample buffer
sample_valid  output  1  sample_out is valid
sample_ready  input  1  FIR datapath accepts the sample
coef_flat  output  NUM_TAPS*COEF_W  active coefficients; tap i occupies bits [i*COEF_W +: COEF_W]
coef_update  output  1  one-cycle pulse when a new bank is committed
loading  output  1  high while in LOAD
err  output  2  sticky flags: bit0 = overflow, bit1 = protocol error

Behaviour:
- Reset (async assert, sync release):
  - sample_valid=0, buffer empty, coef_flat=0, shadow bank=0
  - coef_update=0, loading=0, err=0, FSM=IDLE, tap index=0
  - Strobe synchroniser flops = 0
- Strobe synchroniser and edge detect:
  - cmd_strobe passes through a 2-flop synchroniser, then a delay flop.
  - edge = sync2 & ~delay & ena.
  - cmd_op and data_in are sampled in the cycle edge is high. The source holds them stable from before the strobe rises until ≥4 cycles after.
  - Latency: strobe first sampled high at edge k → command takes effect at edge k+2. A SAMPLE command therefore raises sample_valid after edge k+2.
  - Exactly one command per strobe high pulse; the strobe must be low ≥2 cycles between commands.
- Sample buffer: 2-entry FIFO.
  - Pop: sample_valid & sample_ready.
  - Push (SAMPLE, any FSM state):
    - accepted if count<2, or if count==2 and a pop occurs in the same cycle;
    - otherwise the sample is dropped, err[0] is set, and buffer contents are unchanged.
  - Ordering is FIFO. sample_out is stable while valid & !ready.
- FSM, two states (IDLE, LOAD):
  - IDLE, LOAD_START → LOAD; index=0; loading=1.
  - IDLE, COEF_WRITE → err[1] set, stay IDLE.
  - IDLE, ABORT → clear err to 0.
  - LOAD, COEF_WRITE → shadow[index]=data_in[COEF_W-1:0], index+1.
    - When index reaches NUM_TAPS: copy shadow to coef_flat in one edge, pulse coef_update for one cycle, index=0, go to IDLE.
  - LOAD, LOAD_START → err[1] set; restart with index=0 (shadow contents overwritten by later writes).
  - LOAD, ABORT → discard load, index=0, go to IDLE; coef_flat unchanged; err is not cleared.
- Coefficient bank: coef_flat changes only on a commit edge.
- ena low: edge detect is gated, so any strobe seen while ena=0 is lost. The FIFO still pops normally and the FSM holds its state.
- Reset mid-LOAD: everything returns to reset values, including coef_flat=0.

Test Plan:
- Reset, then SAMPLE with data_in=0x5A, sample_ready=1 → sample_valid high exactly 2 cycles after the strobe is first sampled, sample_out=0x5A, one-cycle valid.
- sample_ready=0; SAMPLEs 0x11, 0x22, 0x33 → buffer holds 0x11, 0x22; err=01; raise ready → pops 0x11 then 0x22; ABORT in IDLE → err=00.
- LOAD_START, then COEF_WRITE 0x01, 0x02, 0x03, 0x04 → coef_flat=0x04030201 after the 4th write, coef_update high exactly 1 cycle, loading falls the same edge.
- LOAD_START, two COEF_WRITEs (0xAA, 0xBB), ABORT → coef_flat keeps its previous value, no coef_update, loading=0, err unchanged.
- COEF_WRITE in IDLE → err=10; SAMPLEs interleaved during a LOAD are delivered in order and the committed bank is correct.
- Assert rst_n low mid-LOAD after 2 writes → coef_flat=0, loading=0, err=0; a strobe while ena=0 → no sample, no state change.
